// File: rtl/rng_gauss_clt_if.sv
// Valid/ready handshake bundle for rng_gauss_clt: uniform samples in, centred CLT sums out.
interface rng_gauss_clt_if #(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned N_LOG2 = 2
);
  localparam int unsigned OUT_W = IN_W + N_LOG2;

  logic [IN_W-1:0]  rand_in;
  logic             rand_valid;
  logic             rand_ready;
  logic [OUT_W-1:0] gauss_out;
  logic             gauss_valid;
  logic             gauss_ready;

  // Upstream RNG plus downstream latent sampler, as seen from outside the block
  modport master (
    output rand_in, rand_valid, gauss_ready,
    input  rand_ready, gauss_out, gauss_valid
  );

  // The CLT block itself
  modport slave (
    input  rand_in, rand_valid, gauss_ready,
    output rand_ready, gauss_out, gauss_valid
  );
endinterface

// File: rtl/rng_gauss_clt.sv
// Central-limit Gaussian approximation: sums 2**N_LOG2 uniform samples and removes the mean.
// Optional RNG lock-up detector enabled with `define STUCK_DETECT_EN.
module rng_gauss_clt #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned N_LOG2    = 2,
  parameter int unsigned STUCK_LIM = 8
) (
  input  logic                clk,
  input  logic                rst,
  rng_gauss_clt_if.slave      bus,
  output logic                stuck_err
);

  localparam int unsigned OUT_W = IN_W + N_LOG2;
  localparam int unsigned N     = 1 << N_LOG2;
  // N*2**(IN_W-1) is exactly 2**(OUT_W-1), the MSB of the accumulator width
  localparam logic [OUT_W-1:0]  OFFSET   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [N_LOG2-1:0] CNT_LAST = N_LOG2'(N - 1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [N_LOG2-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic               accept_c;
  logic [OUT_W-1:0]   sum_c;

  assign accept_c = bus.rand_valid && ready_q;
  assign sum_c    = acc_q + OUT_W'(bus.rand_in);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    case (state_q)
      ACCUM: begin
        if (accept_c) begin
          if (cnt_q == CNT_LAST) begin
            out_d   = sum_c - OFFSET;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            acc_d = sum_c;
            cnt_d = cnt_q + N_LOG2'(1);
          end
        end
      end
      HOLD: begin
        if (bus.gauss_ready) begin
          valid_d = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
    // Registered ready tracks the state entered on this edge
    ready_d = (state_d == ACCUM);
  end

  assign bus.rand_ready  = ready_q;
  assign bus.gauss_out   = out_q;
  assign bus.gauss_valid = valid_q;

`ifdef STUCK_DETECT_EN
  localparam int unsigned RUN_W = $clog2(STUCK_LIM + 1);

  logic [IN_W-1:0]  last_q;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic             seen_q;
  logic             stuck_q;

  // Run length of identical accepted samples, saturating at the limit
  always_comb begin
    run_d = RUN_W'(1);
    if (seen_q && (bus.rand_in == last_q)) begin
      if (run_q < RUN_W'(STUCK_LIM)) run_d = run_q + RUN_W'(1);
      else                           run_d = run_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q  <= '0;
      run_q   <= '0;
      seen_q  <= 1'b0;
      stuck_q <= 1'b0;
    end else if (accept_c) begin
      last_q <= bus.rand_in;
      run_q  <= run_d;
      seen_q <= 1'b1;
      if (run_d == RUN_W'(STUCK_LIM)) stuck_q <= 1'b1;
    end
  end

  assign stuck_err = stuck_q;
`else
  assign stuck_err = 1'b0;
`endif

endmodule

// File: tb/tb_rng_gauss_clt.sv
// Directed self-checking bench for rng_gauss_clt (IN_W=8, N=4, offset 512, STUCK_LIM=8).
module tb_rng_gauss_clt;

  logic clk = 1'b0;
  logic rst;
  logic stuck_err;
  int   checks = 0;
  int   fails  = 0;

`ifdef STUCK_DETECT_EN
  localparam logic STUCK_EXP = 1'b1;
`else
  localparam logic STUCK_EXP = 1'b0;
`endif

  rng_gauss_clt_if #(.IN_W(8), .N_LOG2(2)) rg ();

  rng_gauss_clt #(.IN_W(8), .N_LOG2(2), .STUCK_LIM(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (rg),
    .stuck_err (stuck_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until the accepting edge has passed
  task automatic send(input logic [7:0] v);
    int n = 0;
    rg.rand_in    = v;
    rg.rand_valid = 1'b1;
    while (!rg.rand_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n >= 50) begin
      fails++;
      $display("FAIL send_timeout: rand_ready=%b, required 1 within 50 cycles", rg.rand_ready);
    end
    step();
  endtask

  task automatic test_reset();
    rg.rand_valid  = 1'b0;
    rg.rand_in     = '0;
    rg.gauss_ready = 1'b0;
    rst = 1'b0;
    step();
    step();
    checks++;
    if (rg.gauss_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", rg.gauss_valid); end
    checks++;
    if (rg.gauss_out !== 10'd0) begin fails++; $display("FAIL reset_out: got %h, required 000", rg.gauss_out); end
    checks++;
    if (stuck_err !== 1'b0) begin fails++; $display("FAIL reset_stuck: got %b, required 0", stuck_err); end
    checks++;
    if (rg.rand_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_low: got %b, required 0", rg.rand_ready); end
    rst = 1'b1;
    step();
    checks++;
    if (rg.rand_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %b, required 1", rg.rand_ready); end
  endtask

  task automatic test_midpoint();
    rg.gauss_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(8'h80);
      if (i < 3) begin
        checks++;
        if (rg.gauss_valid !== 1'b0) begin fails++; $display("FAIL mid_early_valid: sample %0d got %b, required 0", i, rg.gauss_valid); end
      end
    end
    rg.rand_valid = 1'b0;
    checks++;
    if (rg.gauss_valid !== 1'b1) begin fails++; $display("FAIL mid_valid: got %b, required 1", rg.gauss_valid); end
    checks++;
    if (rg.gauss_out !== 10'd0) begin fails++; $display("FAIL mid_out: got %0d, required 0", $signed(rg.gauss_out)); end
    checks++;
    if (rg.rand_ready !== 1'b0) begin fails++; $display("FAIL mid_ready_hold: got %b, required 0", rg.rand_ready); end
    step();
    checks++;
    if (rg.gauss_valid !== 1'b0) begin fails++; $display("FAIL mid_valid_drop: got %b, required 0", rg.gauss_valid); end
    checks++;
    if (rg.rand_ready !== 1'b1) begin fails++; $display("FAIL mid_ready_back: got %b, required 1", rg.rand_ready); end
  endtask

  task automatic test_extremes();
    rg.gauss_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'hFF);
    rg.rand_valid = 1'b0;
    checks++;
    if (rg.gauss_valid !== 1'b1 || rg.gauss_out !== 10'(508)) begin
      fails++; $display("FAIL max_out: got valid=%b %0d, required 1 508", rg.gauss_valid, $signed(rg.gauss_out));
    end
    step();
    for (int i = 0; i < 4; i++) send(8'h00);
    rg.rand_valid = 1'b0;
    checks++;
    if (rg.gauss_valid !== 1'b1 || rg.gauss_out !== 10'h200) begin
      fails++; $display("FAIL min_out: got valid=%b %0d, required 1 -512", rg.gauss_valid, $signed(rg.gauss_out));
    end
    step();
  endtask

  task automatic test_bubbles();
    logic [7:0] vals [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
    rg.gauss_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vals[i]);
      if (i < 3) begin
        rg.rand_valid = 1'b0;
        rg.rand_in    = 8'hFF;
        step();
        checks++;
        if (rg.gauss_valid !== 1'b0) begin fails++; $display("FAIL bubble_early_valid: gap %0d got %b, required 0", i, rg.gauss_valid); end
      end
    end
    rg.rand_valid = 1'b0;
    checks++;
    if (rg.gauss_valid !== 1'b1 || rg.gauss_out !== 10'(-412)) begin
      fails++; $display("FAIL bubble_out: got valid=%b %0d, required 1 -412", rg.gauss_valid, $signed(rg.gauss_out));
    end
    step();
  endtask

  task automatic test_hold();
    rg.gauss_ready = 1'b0;
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    for (int i = 0; i < 5; i++) begin
      rg.rand_valid = (i % 2 == 0);
      rg.rand_in    = 8'hAA;
      step();
      checks++;
      if (rg.gauss_valid !== 1'b1 || rg.gauss_out !== 10'(-502) || rg.rand_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable: cycle %0d got valid=%b out=%0d ready=%b, required 1 -502 0",
                 i, rg.gauss_valid, $signed(rg.gauss_out), rg.rand_ready);
      end
    end
    rg.rand_valid  = 1'b0;
    rg.gauss_ready = 1'b1;
    step();
    checks++;
    if (rg.gauss_valid !== 1'b0 || rg.rand_ready !== 1'b1) begin
      fails++; $display("FAIL hold_release: got valid=%b ready=%b, required 0 1", rg.gauss_valid, rg.rand_ready);
    end
    for (int i = 0; i < 4; i++) send(8'h80);
    rg.rand_valid = 1'b0;
    checks++;
    if (rg.gauss_valid !== 1'b1 || rg.gauss_out !== 10'd0) begin
      fails++; $display("FAIL hold_resume: got valid=%b %0d, required 1 0", rg.gauss_valid, $signed(rg.gauss_out));
    end
    step();
  endtask

  task automatic test_reset_mid();
    rg.gauss_ready = 1'b1;
    send(8'hFF); send(8'hFF);
    rg.rand_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if (rg.rand_ready !== 1'b0 || rg.gauss_valid !== 1'b0) begin
      fails++; $display("FAIL midreset_state: got ready=%b valid=%b, required 0 0", rg.rand_ready, rg.gauss_valid);
    end
    step();
    for (int i = 0; i < 4; i++) send(8'h80);
    rg.rand_valid = 1'b0;
    checks++;
    if (rg.gauss_valid !== 1'b1 || rg.gauss_out !== 10'd0) begin
      fails++; $display("FAIL midreset_out: got valid=%b %0d, required 1 0", rg.gauss_valid, $signed(rg.gauss_out));
    end
    step();
  endtask

  task automatic test_stuck();
    rg.gauss_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(8'h00);
      if (i == 6) begin
        checks++;
        if (stuck_err !== 1'b0) begin fails++; $display("FAIL stuck_early: got %b after 7 accepts, required 0", stuck_err); end
      end
    end
    rg.rand_valid = 1'b0;
    checks++;
    if (stuck_err !== STUCK_EXP) begin fails++; $display("FAIL stuck_set: got %b, required %b", stuck_err, STUCK_EXP); end
    checks++;
    if (rg.gauss_valid !== 1'b1 || rg.gauss_out !== 10'h200) begin
      fails++; $display("FAIL stuck_datapath: got valid=%b %0d, required 1 -512", rg.gauss_valid, $signed(rg.gauss_out));
    end
    step();
    send(8'h55);
    rg.rand_valid = 1'b0;
    step();
    checks++;
    if (stuck_err !== STUCK_EXP) begin fails++; $display("FAIL stuck_sticky: got %b, required %b", stuck_err, STUCK_EXP); end
  endtask

  initial begin
    test_reset();
    test_midpoint();
    test_extremes();
    test_bubbles();
    test_hold();
    test_reset_mid();
    test_stuck();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
